// File: rtl/cpu6_shft_serial_pkg.sv
// Shared constants and state encoding for the cpu6 serial shifter.
// The direction encoding here is also used by the ALU decoder.
package cpu6_shft_serial_pkg;

    localparam int CPU6_SHFT_DATA_W     = 32;
    localparam int CPU6_SHFT_SHAMT_W    = 5;
    localparam int CPU6_SHFT_STATE_SIZE = 2;

    localparam logic CPU6_SHFT_LEFT  = 1'b0;
    localparam logic CPU6_SHFT_RIGHT = 1'b1;

    typedef enum logic [CPU6_SHFT_STATE_SIZE-1:0] {
        CPU6_SHFT_IDLE = 2'd0,
        CPU6_SHFT_RUN  = 2'd1,
        CPU6_SHFT_DONE = 2'd2
    } cpu6_shft_state_t;

endpackage

// File: rtl/cpu6_shft_serial_if.sv
// Execute-stage to shifter bus: request fields in, status and result out.
// Handshake: start is taken on a rising edge only while ready=1; a start seen while
// ready=0 is dropped (not queued), and done is a single-cycle valid for result.
interface cpu6_shft_serial_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic               shft_lr;
    logic               shft_la;
    logic [DATA_W-1:0]  opa;
    logic [SHAMT_W-1:0] shamt;
    logic               flush;
    logic               ready;
    logic               busy;
    logic               done;
    logic [DATA_W-1:0]  result;

    modport master (
        output start, shft_lr, shft_la, opa, shamt, flush,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, shft_lr, shft_la, opa, shamt, flush,
        output ready, busy, done, result
    );
endinterface

// File: rtl/cpu6_shft_step.sv
// Single-bit shift step: left shifts in zero, right shifts in zero or the
// current MSB when arith is set.
module cpu6_shft_step
    import cpu6_shft_serial_pkg::*;
#(
    parameter int DATA_W = CPU6_SHFT_DATA_W
) (
    input  logic [DATA_W-1:0] din,
    input  logic              dir,
    input  logic              arith,
    output logic [DATA_W-1:0] dout
);
    always_comb begin
        dout = din;
        if (dir == CPU6_SHFT_LEFT) begin
            dout = {din[DATA_W-2:0], 1'b0};
        end else begin
            dout = {arith & din[DATA_W-1], din[DATA_W-1:1]};
        end
    end
endmodule

// File: rtl/cpu6_shft_serial.sv
// Serial shifter for the cpu6 execute stage: one bit per cycle, stalls EX via busy,
// and emits a one-cycle done with the registered result.
module cpu6_shft_serial
    import cpu6_shft_serial_pkg::*;
#(
    parameter int DATA_W  = CPU6_SHFT_DATA_W,
    parameter int SHAMT_W = CPU6_SHFT_SHAMT_W
) (
    input  logic             clk,
    input  logic             resetn,
    cpu6_shft_serial_if.slave bus,
    output cpu6_shft_state_t dbg_state
);
    cpu6_shft_state_t   state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic               dir_q, dir_d;
    logic               arith_q, arith_d;
    logic [DATA_W-1:0]  step_out;

    cpu6_shft_step #(.DATA_W(DATA_W)) u_step (
        .din   (shreg_q),
        .dir   (dir_q),
        .arith (arith_q),
        .dout  (step_out)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= CPU6_SHFT_IDLE;
            shreg_q <= '0;
            count_q <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
        end
    end

    // The shift register doubles as the result register, so it is held in IDLE.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        dir_d   = dir_q;
        arith_d = arith_q;
        unique case (state_q)
            CPU6_SHFT_IDLE: begin
                if (bus.start && !bus.flush) begin
                    shreg_d = bus.opa;
                    count_d = bus.shamt;
                    dir_d   = bus.shft_lr;
                    arith_d = bus.shft_la & bus.shft_lr;
                    state_d = (bus.shamt == '0) ? CPU6_SHFT_DONE : CPU6_SHFT_RUN;
                end
            end
            CPU6_SHFT_RUN: begin
                if (bus.flush) begin
                    state_d = CPU6_SHFT_IDLE;
                end else begin
                    shreg_d = step_out;
                    count_d = count_q - 1'b1;
                    if (count_q == SHAMT_W'(1)) begin
                        state_d = CPU6_SHFT_DONE;
                    end
                end
            end
            CPU6_SHFT_DONE: begin
                state_d = CPU6_SHFT_IDLE;
            end
            default: begin
                state_d = CPU6_SHFT_IDLE;
            end
        endcase
    end

    // Flush gating of done is the only input-to-output path.
    assign bus.ready  = (state_q == CPU6_SHFT_IDLE);
    assign bus.busy   = (state_q == CPU6_SHFT_RUN) || (state_q == CPU6_SHFT_DONE);
    assign bus.done   = (state_q == CPU6_SHFT_DONE) && !bus.flush;
    assign bus.result = shreg_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_cpu6_shft_serial.sv
// Bench for cpu6_shft_serial: a latency/result model checked every cycle, directed
// scenarios with hand-computed results, then randomized start/flush/reset traffic.
module tb_cpu6_shft_serial;
  import cpu6_shft_serial_pkg::*;

  localparam int W = 32;

  logic clk;
  logic resetn;
  cpu6_shft_state_t dbg_state;

  cpu6_shft_serial_if #(.DATA_W(W), .SHAMT_W(5)) bus ();

  cpu6_shft_serial #(.DATA_W(W), .SHAMT_W(5)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_shift(input logic [W-1:0] a, input int sh,
                                               input bit lr, input bit la);
    if (!lr) return a << sh;
    if (la) return $unsigned($signed(a) >>> sh);
    return a >> sh;
  endfunction

  // behavioural model: an accepted shift completes shamt+1 cycles later
  logic [W-1:0] exp_q[$];
  bit           m_busy = 1'b0;
  int           m_wait = 0;
  bit           m_known = 1'b0;
  logic [W-1:0] m_res = '0;

  always @(posedge clk) begin
    if (!resetn) begin
      m_busy = 1'b0;
      m_wait = 0;
      exp_q.delete();
      m_res = '0;
      m_known = 1'b1;
    end else if (!m_busy) begin
      if (bus.start && !bus.flush) begin
        exp_q.push_back(model_shift(bus.opa, int'(bus.shamt), bus.shft_lr, bus.shft_la));
        m_wait = int'(bus.shamt);
        m_busy = 1'b1;
        m_known = 1'b0;
      end
    end else if (bus.flush) begin
      m_busy = 1'b0;
      exp_q.delete();
      m_known = 1'b0;
    end else if (m_wait == 0) begin
      m_busy = 1'b0;
      m_res = exp_q.pop_front();
      m_known = 1'b1;
    end else begin
      m_wait--;
    end
  end

  // scoreboard compare, every cycle after the first edge
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("ready", W'(bus.ready), W'(!m_busy));
      check("busy", W'(bus.busy), W'(m_busy));
      check("done", W'(bus.done), W'(m_busy && m_wait == 0 && !bus.flush));
      if (m_busy && m_wait == 0 && exp_q.size() > 0)
        check("result_done", bus.result, exp_q[0]);
      else if (!m_busy && m_known)
        check("result_hold", bus.result, m_res);
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string name, input logic [W-1:0] a, input int sh,
                         input bit lr, input bit la, input logic [W-1:0] exp_res,
                         input int exp_lat);
    int cyc;
    bit seen;
    next_cycle();
    bus.start = 1'b1;
    bus.opa = a;
    bus.shamt = 5'(sh);
    bus.shft_lr = lr;
    bus.shft_la = la;
    next_cycle();
    bus.start = 1'b0;
    cyc = 1;
    seen = 1'b0;
    while (cyc <= 40 && !seen) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
      else begin
        next_cycle();
        cyc++;
      end
    end
    check({name, "_latency"}, W'(cyc), W'(exp_lat));
    check({name, "_result"}, bus.result, exp_res);
  endtask

  initial begin
    resetn = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.shft_lr = 1'b0;
    bus.shft_la = 1'b0;
    bus.opa = '0;
    bus.shamt = '0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("reset_ready", W'(bus.ready), 32'd1);
    check("reset_result", bus.result, 32'h0);
    next_cycle();
    resetn = 1'b1;

    run_one("sll31", 32'h0000_0001, 31, 1'b0, 1'b0, 32'h8000_0000, 32);
    run_one("sra4", 32'h8000_0000, 4, 1'b1, 1'b1, 32'hF800_0000, 5);
    run_one("srl4", 32'h8000_0000, 4, 1'b1, 1'b0, 32'h0800_0000, 5);
    run_one("sll4_la", 32'h8000_0000, 4, 1'b0, 1'b1, 32'h0000_0000, 5);
    run_one("zero", 32'h1234_5678, 0, 1'b0, 1'b0, 32'h1234_5678, 1);

    // start held high: only IDLE cycles accept
    next_cycle();
    bus.start = 1'b1;
    bus.opa = 32'h1234_5678;
    bus.shamt = 5'd0;
    next_cycle();
    bus.opa = 32'hDEAD_BEEF;
    @(negedge clk);
    check("b2b_done1", W'(bus.done), 32'd1);
    check("b2b_ready1", W'(bus.ready), 32'd0);
    check("b2b_res1", bus.result, 32'h1234_5678);
    next_cycle();
    bus.opa = 32'h0000_ABCD;
    @(negedge clk);
    check("b2b_ready2", W'(bus.ready), 32'd1);
    next_cycle();
    bus.start = 1'b0;
    @(negedge clk);
    check("b2b_done2", W'(bus.done), 32'd1);
    check("b2b_res2", bus.result, 32'h0000_ABCD);

    // flush mid-run
    next_cycle();
    bus.start = 1'b1;
    bus.opa = 32'hA5A5_0F0F;
    bus.shamt = 5'd10;
    next_cycle();
    bus.start = 1'b0;
    repeat (3) next_cycle();
    bus.flush = 1'b1;
    next_cycle();
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_run_ready", W'(bus.ready), 32'd1);
    check("flush_run_done", W'(bus.done), 32'd0);

    // flush coincident with the done cycle
    next_cycle();
    bus.start = 1'b1;
    bus.shamt = 5'd3;
    next_cycle();
    bus.start = 1'b0;
    repeat (3) next_cycle();
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_done_done", W'(bus.done), 32'd0);
    check("flush_done_busy", W'(bus.busy), 32'd1);
    next_cycle();
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_done_ready", W'(bus.ready), 32'd1);

    // flush and start together in IDLE
    next_cycle();
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.shamt = 5'd2;
    next_cycle();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_idle_ready", W'(bus.ready), 32'd1);

    // result hold while idle
    run_one("sll8", 32'h0000_00FF, 8, 1'b0, 1'b0, 32'h0000_FF00, 9);
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      bus.opa = $urandom;
      bus.shamt = 5'($urandom_range(0, 31));
      @(negedge clk);
      check("hold_result", bus.result, 32'h0000_FF00);
    end

    // reset mid-shift
    next_cycle();
    bus.start = 1'b1;
    bus.opa = 32'hFFFF_0000;
    bus.shamt = 5'd20;
    bus.shft_lr = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    repeat (4) next_cycle();
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", W'(bus.ready), 32'd1);
    check("rst_mid_busy", W'(bus.busy), 32'd0);
    check("rst_mid_result", bus.result, 32'h0);
    repeat (25) next_cycle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      bus.start = 1'($urandom_range(0, 1));
      bus.flush = ($urandom_range(0, 19) == 0);
      resetn = ($urandom_range(0, 149) != 0);
      bus.opa = $urandom;
      bus.shamt = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      bus.shft_lr = 1'($urandom_range(0, 1));
      bus.shft_la = 1'($urandom_range(0, 1));
    end
    next_cycle();
    resetn = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    repeat (40) next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
